// File: rtl/ed25519_point_compress.sv
// Ed25519 point compression: Fermat inversion of Z, affine x/y, 256-bit encoding.
// One shared modular multiplier: MUL cycle folds the product once, RED cycle finishes it.
module ed25519_point_compress (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [254:0] p_x_i,
  input  logic [254:0] p_y_i,
  input  logic [254:0] p_z_i,
  input  logic [254:0] p_t_i,
  output logic [255:0] enc_o,
  output logic [254:0] aff_x_o,
  output logic [254:0] aff_y_o,
  output logic         z_zero_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [15:0]  cycles_o
);

  localparam logic [254:0] P   = {255{1'b1}} - 255'd18;
  localparam logic [254:0] EXP = P - 255'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_INV_SQ, S_INV_MUL, S_XMUL, S_YMUL, S_ENC, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          ph_q, ph_d;
  logic [7:0]    idx_q, idx_d;
  logic [254:0]  acc_q, acc_d, x_q, x_d, y_q, y_d, z_q, z_d;
  logic [259:0]  r_q, r_d;
  logic [255:0]  enc_q, enc_d;
  logic [254:0]  aff_x_q, aff_x_d, aff_y_q, aff_y_d;
  logic          z_zero_q, z_zero_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]   cycles_q, cycles_d;

  logic [254:0]  mul_a, mul_b, red;
  logic [509:0]  prod;
  logic [259:0]  fold1;
  logic [255:0]  fold2, fold2_sub;
  logic          is_mul;
  logic          unused_sig;

  assign unused_sig = ^{p_t_i, fold2_sub[255]};

  always_comb begin
    mul_a = acc_q;
    mul_b = acc_q;
    case (state_q)
      S_INV_MUL: mul_b = z_q;
      S_XMUL:    mul_a = x_q;
      S_YMUL:    mul_a = y_q;
      default:   ;
    endcase
  end

  // 2^255 == 19 (mod p): two folds bound the value below 2p, one subtract finishes.
  assign prod      = {255'd0, mul_a} * {255'd0, mul_b};
  assign fold1     = {5'd0, prod[254:0]} + {5'd0, prod[509:255]} * 260'd19;
  assign fold2     = {1'b0, r_q[254:0]} + {251'd0, r_q[259:255]} * 256'd19;
  assign fold2_sub = fold2 - {1'b0, P};
  assign red       = (fold2 >= {1'b0, P}) ? fold2_sub[254:0] : fold2[254:0];

  assign is_mul = (state_q == S_INV_SQ) || (state_q == S_INV_MUL) ||
                  (state_q == S_XMUL)   || (state_q == S_YMUL);

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    r_d      = r_q;
    enc_d    = enc_q;
    aff_x_d  = aff_x_q;
    aff_y_d  = aff_y_q;
    z_zero_d = z_zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cycles_d = cycles_q;

    if (state_q != S_IDLE && state_q != S_DONE)
      cycles_d = cycles_q + 16'd1;

    if (is_mul) begin
      ph_d = ~ph_q;
      if (!ph_q)
        r_d = fold1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d      = p_x_i;
          y_d      = p_y_i;
          z_d      = p_z_i;
          acc_d    = p_z_i;
          idx_d    = 8'd253;
          ph_d     = 1'b0;
          busy_d   = 1'b1;
          cycles_d = 16'd0;
          state_d  = S_INV_SQ;
        end
      end
      S_INV_SQ: begin
        if (ph_q) begin
          acc_d = red;
          if (EXP[idx_q])
            state_d = S_INV_MUL;
          else if (idx_q == 8'd0)
            state_d = S_XMUL;
          else
            idx_d = idx_q - 8'd1;
        end
      end
      S_INV_MUL: begin
        if (ph_q) begin
          acc_d = red;
          if (idx_q == 8'd0) begin
            state_d = S_XMUL;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_INV_SQ;
          end
        end
      end
      S_XMUL: begin
        if (ph_q) begin
          aff_x_d = red;
          state_d = S_YMUL;
        end
      end
      S_YMUL: begin
        if (ph_q) begin
          aff_y_d = red;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        enc_d    = {aff_x_q[0], aff_y_q};
        z_zero_d = (z_q == 255'd0) || (z_q == P);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      idx_q    <= 8'd0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      r_q      <= '0;
      enc_q    <= '0;
      aff_x_q  <= '0;
      aff_y_q  <= '0;
      z_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      r_q      <= r_d;
      enc_q    <= enc_d;
      aff_x_q  <= aff_x_d;
      aff_y_q  <= aff_y_d;
      z_zero_q <= z_zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  assign enc_o    = enc_q;
  assign aff_x_o  = aff_x_q;
  assign aff_y_o  = aff_y_q;
  assign z_zero_o = z_zero_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign cycles_o = cycles_q;

endmodule

// File: tb/tb_ed25519_point_compress.sv
// Bench for ed25519_point_compress: vector table, random points vs. a modular-arithmetic model,
// start-while-busy handshake and mid-operation reset.
module tb_ed25519_point_compress;

  localparam logic [254:0] P   = {255{1'b1}} - 255'd18;
  localparam logic [254:0] EXP = P - 255'd2;
  localparam logic [254:0] GX  = 255'h216936D3CD6E53FE_C0A4E231FDD6DC5C_692CC7609525A7B2_C9562D608F25D51A;
  localparam logic [254:0] GY  = 255'h6666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam int LAT = 1017;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [254:0] p_x_i = '0, p_y_i = '0, p_z_i = '0, p_t_i = '0;
  logic [255:0] enc_o;
  logic [254:0] aff_x_o, aff_y_o;
  logic         z_zero_o, busy_o, done_o;
  logic [15:0]  cycles_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ed25519_point_compress dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .p_x_i(p_x_i), .p_y_i(p_y_i), .p_z_i(p_z_i), .p_t_i(p_t_i),
    .enc_o(enc_o), .aff_x_o(aff_x_o), .aff_y_o(aff_y_o),
    .z_zero_o(z_zero_o), .busy_o(busy_o), .done_o(done_o), .cycles_o(cycles_o)
  );

  typedef struct {
    logic [254:0] x, y, z;
    logic [255:0] enc;
    logic [254:0] ax, ay;
    logic         zz;
  } vec_t;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = ({257'd0, a} * {257'd0, b}) % {257'd0, P};
    return t[254:0];
  endfunction

  // Plain square-and-multiply over the whole exponent; z^(p-2) is 1/z (0 for z == 0).
  function automatic logic [254:0] finv(input logic [254:0] z);
    logic [254:0] r;
    logic [254:0] b;
    r = 255'd1;
    b = mulmod(z, 255'd1);
    for (int i = 254; i >= 0; i--) begin
      r = mulmod(r, r);
      if (EXP[i]) r = mulmod(r, b);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                              input logic [255:0] enc, input logic [254:0] ax,
                              input logic [254:0] ay, input logic zz);
    vec_t v;
    v.x = x; v.y = y; v.z = z; v.enc = enc; v.ax = ax; v.ay = ay; v.zz = zz;
    return v;
  endfunction

  function automatic vec_t model(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z);
    logic [254:0] zi, ax, ay;
    zi = finv(z);
    ax = mulmod(x, zi);
    ay = mulmod(y, zi);
    return mk(x, y, z, {ax[0], ay}, ax, ay, mulmod(z, 255'd1) == 255'd0);
  endfunction

  function automatic logic [254:0] rand255();
    logic [255:0] t;
    t = '0;
    for (int k = 0; k < 8; k++) t = {t[223:0], 32'($urandom())};
    return t[254:0];
  endfunction

  task automatic launch(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z);
    p_x_i   = x;
    p_y_i   = y;
    p_z_i   = z;
    p_t_i   = 255'($urandom());
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    p_x_i   = 255'd9;
    p_y_i   = 255'd11;
    p_z_i   = 255'd13;
  endtask

  task automatic wait_done(input bit poke, output int lat);
    lat = -1;
    for (int n = 1; n <= 1100; n++) begin
      start_i = poke && (n == 1 || n == 500 || n == LAT);
      @(posedge clk_i); #1;
      if (done_o) begin
        lat = n;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit poke, input string tag);
    int lat;
    launch(v.x, v.y, v.z);
    check($sformatf("%s/busy", tag), 256'(busy_o), 256'd1);
    wait_done(poke, lat);
    check($sformatf("%s/latency", tag), 256'(lat), 256'(LAT));
    check($sformatf("%s/cycles", tag), 256'(cycles_o), 256'(LAT));
    check($sformatf("%s/enc", tag), enc_o, v.enc);
    check($sformatf("%s/aff_x", tag), {1'b0, aff_x_o}, {1'b0, v.ax});
    check($sformatf("%s/aff_y", tag), {1'b0, aff_y_o}, {1'b0, v.ay});
    check($sformatf("%s/z_zero", tag), 256'(z_zero_o), 256'(v.zz));
    start_i = poke;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check($sformatf("%s/done_pulse", tag), 256'(done_o), 256'd0);
    check($sformatf("%s/busy_after", tag), 256'(busy_o), 256'd0);
    check($sformatf("%s/enc_hold", tag), enc_o, v.enc);
  endtask

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   seen;

    tbl[0] = mk(GX, GY, 255'd1, {1'b0, GY}, GX, GY, 1'b0);
    tbl[1] = mk(mulmod(GX, 255'd2), mulmod(GY, 255'd2), 255'd2, {1'b0, GY}, GX, GY, 1'b0);
    tbl[2] = mk(P - GX, GY, 255'd1, {1'b1, GY}, P - GX, GY, 1'b0);
    tbl[3] = mk(255'd0, 255'd1, 255'd1, 256'd1, 255'd0, 255'd1, 1'b0);
    tbl[4] = mk(255'd5, 255'd7, 255'd0, 256'd0, 255'd0, 255'd0, 1'b1);
    tbl[5] = mk(255'd5, 255'd7, P, 256'd0, 255'd0, 255'd0, 1'b1);
    tbl[6] = model(P + 255'd3, {255{1'b1}}, 255'd3);

    repeat (3) @(posedge clk_i);
    #1;
    check("rst/enc", enc_o, 256'd0);
    check("rst/aff_x", {1'b0, aff_x_o}, 256'd0);
    check("rst/busy_done", {254'd0, busy_o, done_o}, 256'd0);
    check("rst/cycles", 256'(cycles_o), 256'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 3; i++) begin
      v = model(rand255(), rand255(), rand255());
      run_vec(v, 1'b0, $sformatf("rand%0d", i));
    end

    run_vec(tbl[0], 1'b1, "handshake");

    launch(GX, GY, 255'd1);
    repeat (599) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midrst/enc", enc_o, 256'd0);
    check("midrst/aff_x", {1'b0, aff_x_o}, 256'd0);
    check("midrst/aff_y", {1'b0, aff_y_o}, 256'd0);
    check("midrst/flags", {253'd0, z_zero_o, busy_o, done_o}, 256'd0);
    check("midrst/cycles", 256'(cycles_o), 256'd0);
    seen = 1'b0;
    repeat (1100) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    check("midrst/no_done", 256'(seen), 256'd0);
    run_vec(tbl[0], 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
